// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, immediate-select, ALU and ID-stage FSM definitions
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_MUL   = 4'b1011,
    ALU_DIV   = 4'b1100
  } alu_ctrl_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } id_state_e;

  typedef struct packed {
    imm_src_e  imm_src;
    alu_ctrl_e alu_ctrl;
    logic      alu_src;
    logic [1:0] result_src;
    logic      reg_write;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      is_load;
    logic      illegal;
    logic      is_div;
    logic      is_upper;
  } dec_t;

  // SUB only exists for register-register ops; funct7[5] picks SRA for both forms
  function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                               input logic is_reg);
    case (funct3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ctrl_if.sv
// rtl/id_ctrl_if.sv - ID/EX pipeline register bundle
interface id_ctrl_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src;
  logic [1:0]  id_result_src;
  logic        id_reg_write;
  logic        id_mem_write;
  logic        id_branch;
  logic        id_jump;
  logic        id_is_load;
  logic        id_illegal;
  logic        id_mdu_start;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_alu_ctrl, id_alu_src,
           id_result_src, id_reg_write, id_mem_write, id_branch, id_jump, id_is_load,
           id_illegal, id_mdu_start
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_alu_ctrl, id_alu_src,
           id_result_src, id_reg_write, id_mem_write, id_branch, id_jump, id_is_load,
           id_illegal, id_mdu_start
  );
endinterface

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational opcode/funct decode for the ID stage
module id_decoder
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.imm_src  = IMM_I;
    dec.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.reg_write  = 1'b1;
        dec.is_load    = 1'b1;
      end
      OP_STORE: begin
        dec.imm_src   = IMM_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_src  = IMM_B;
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
      end
      OP_JAL: begin
        dec.imm_src    = IMM_J;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_from_funct(funct3, funct7[5], 1'b0);
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_MULDIV) begin
          // funct3[2] separates the multi-cycle divide group from single-cycle multiplies
          dec.alu_ctrl = funct3[2] ? ALU_DIV : ALU_MUL;
          dec.is_div   = funct3[2];
        end else begin
          dec.alu_ctrl = alu_from_funct(funct3, funct7[5], 1'b1);
        end
      end
      OP_LUI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
        dec.is_upper  = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.is_upper  = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ctrl.sv
// rtl/id_ctrl.sv - ID stage: hazard detection, divider-wait FSM and ID/EX registers
module id_ctrl
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic [1:0]       imm_src,
  input  logic [31:0]      imm_ext,
  input  logic             ex_flush,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             mdu_done,
  output logic             id_stall,
  id_ctrl_if.master        idex
);

  dec_t        dec;
  id_state_e   state;
  logic        load_use;
  logic        issue_div;
  logic [31:0] imm_sel;

  id_decoder u_dec (
    .opcode (if_instr[6:0]),
    .funct3 (if_instr[14:12]),
    .funct7 (if_instr[31:25]),
    .dec    (dec)
  );

  assign imm_src   = dec.imm_src;
  assign load_use  = if_valid && ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == if_instr[19:15]) || (ex_rd == if_instr[24:20]));
  assign issue_div = if_valid && dec.is_div;
  assign imm_sel   = dec.is_upper ? {if_instr[31:12], 12'b0} : imm_ext;

  always_comb begin
    id_stall = 1'b0;
    if (ex_flush)                  id_stall = 1'b0;
    else if (state == ST_MDU_WAIT) id_stall = 1'b1;
    else                           id_stall = load_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_RUN;
      idex.id_valid      <= 1'b0;
      idex.id_pc         <= '0;
      idex.id_imm        <= '0;
      idex.id_rs1        <= '0;
      idex.id_rs2        <= '0;
      idex.id_rd         <= '0;
      idex.id_alu_ctrl   <= '0;
      idex.id_alu_src    <= 1'b0;
      idex.id_result_src <= '0;
      idex.id_reg_write  <= 1'b0;
      idex.id_mem_write  <= 1'b0;
      idex.id_branch     <= 1'b0;
      idex.id_jump       <= 1'b0;
      idex.id_is_load    <= 1'b0;
      idex.id_illegal    <= 1'b0;
      idex.id_mdu_start  <= 1'b0;
    end else if (ex_flush || (state == ST_RUN && load_use)) begin
      state              <= ST_RUN;
      idex.id_valid      <= 1'b0;
      idex.id_reg_write  <= 1'b0;
      idex.id_mem_write  <= 1'b0;
      idex.id_branch     <= 1'b0;
      idex.id_jump       <= 1'b0;
      idex.id_is_load    <= 1'b0;
      idex.id_illegal    <= 1'b0;
      idex.id_mdu_start  <= 1'b0;
    end else if (state == ST_MDU_WAIT) begin
      // ID/EX holds the divide while it runs; only the start strobe drops
      idex.id_mdu_start  <= 1'b0;
      if (mdu_done) state <= ST_RUN;
    end else begin
      state              <= issue_div ? ST_MDU_WAIT : ST_RUN;
      idex.id_valid      <= if_valid;
      idex.id_pc         <= if_pc;
      idex.id_imm        <= imm_sel;
      idex.id_rs1        <= if_instr[19:15];
      idex.id_rs2        <= if_instr[24:20];
      idex.id_rd         <= if_instr[11:7];
      idex.id_alu_ctrl   <= dec.alu_ctrl;
      idex.id_alu_src    <= dec.alu_src;
      idex.id_result_src <= dec.result_src;
      idex.id_reg_write  <= if_valid && dec.reg_write;
      idex.id_mem_write  <= if_valid && dec.mem_write;
      idex.id_branch     <= if_valid && dec.branch;
      idex.id_jump       <= if_valid && dec.jump;
      idex.id_is_load    <= if_valid && dec.is_load;
      idex.id_illegal    <= if_valid && dec.illegal;
      idex.id_mdu_start  <= issue_div;
    end
  end

endmodule

// File: tb/tb_id_ctrl.sv
// tb/tb_id_ctrl.sv - directed self-checking bench for id_ctrl
module tb_id_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  imm_src;
  logic [31:0] imm_ext;
  logic        ex_flush;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        mdu_done;
  logic        id_stall;

  int n_tests   = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int s0;

  localparam logic [31:0] I_ADDI = 32'hFFF00293;  // addi x5,x0,-1
  localparam logic [31:0] I_ADD  = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] I_DIV  = 32'h023140B3;  // div x1,x2,x3
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;  // beq x1,x2,-4
  localparam logic [31:0] I_LUI  = 32'h123450B7;  // lui x1,0x12345
  localparam logic [31:0] I_BAD  = 32'h00000FFF;  // opcode 0x7F, rd=31
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_SW   = 32'h00112023;  // sw x1,0(x2)

  always #5 clk = ~clk;

  id_ctrl_if idex ();

  id_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .imm_src    (imm_src),
    .imm_ext    (imm_ext),
    .ex_flush   (ex_flush),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .mdu_done   (mdu_done),
    .id_stall   (id_stall),
    .idex       (idex)
  );

  // neighbouring immediate extender
  always_comb begin
    case (imm_src)
      2'b00:   imm_ext = {{20{if_instr[31]}}, if_instr[31:20]};
      2'b01:   imm_ext = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      2'b10:   imm_ext = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      default: imm_ext = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    endcase
  end

  always @(negedge clk) if (idex.id_mdu_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; ex_flush = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; mdu_done = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    check("rst_valid", {31'b0, idex.id_valid}, 32'd0);
    check("rst_stall", {31'b0, id_stall}, 32'd0);
    check("rst_start", {31'b0, idex.id_mdu_start}, 32'd0);
    check("rst_imm", idex.id_imm, 32'd0);
    check("rst_pc", idex.id_pc, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // addi x5,x0,-1
    drive(1'b1, I_ADDI, 32'h100);
    #1;
    check("addi_imm_src", {30'b0, imm_src}, 32'd0);
    check("addi_stall", {31'b0, id_stall}, 32'd0);
    tick();
    check("addi_valid", {31'b0, idex.id_valid}, 32'd1);
    check("addi_imm", idex.id_imm, 32'hFFFFFFFF);
    check("addi_rd", {27'b0, idex.id_rd}, 32'd5);
    check("addi_alu_src", {31'b0, idex.id_alu_src}, 32'd1);
    check("addi_reg_write", {31'b0, idex.id_reg_write}, 32'd1);
    check("addi_pc", idex.id_pc, 32'h100);

    // load-use on rs1, then add issues the cycle after
    ex_is_load = 1'b1; ex_rd = 5'd5;
    drive(1'b1, I_ADD, 32'h104);
    #1;
    check("lu_stall", {31'b0, id_stall}, 32'd1);
    tick();
    check("lu_bubble_valid", {31'b0, idex.id_valid}, 32'd0);
    check("lu_bubble_we", {31'b0, idex.id_reg_write}, 32'd0);
    ex_is_load = 1'b0; ex_rd = 5'd0;
    #1;
    check("lu_release", {31'b0, id_stall}, 32'd0);
    tick();
    check("add_valid", {31'b0, idex.id_valid}, 32'd1);
    check("add_rd", {27'b0, idex.id_rd}, 32'd6);
    check("add_rs1", {27'b0, idex.id_rs1}, 32'd5);
    check("add_rs2", {27'b0, idex.id_rs2}, 32'd7);
    check("add_alu_src", {31'b0, idex.id_alu_src}, 32'd0);

    // hazard on rs2; no hazard for ex_rd=0
    ex_is_load = 1'b1; ex_rd = 5'd7;
    #1;
    check("lu_rs2_stall", {31'b0, id_stall}, 32'd1);
    ex_rd = 5'd0;
    #1;
    check("lu_x0_nostall", {31'b0, id_stall}, 32'd0);
    ex_is_load = 1'b0;

    // div with mdu_done at +7
    s0 = start_cnt;
    drive(1'b1, I_DIV, 32'h200);
    tick();
    check("div_start", {31'b0, idex.id_mdu_start}, 32'd1);
    check("div_rd", {27'b0, idex.id_rd}, 32'd1);
    drive(1'b1, I_ADDI, 32'h204);
    #1;
    check("div_stall", {31'b0, id_stall}, 32'd1);
    for (int k = 1; k <= 6; k++) tick();
    check("div_start_low", {31'b0, idex.id_mdu_start}, 32'd0);
    check("div_hold_rd", {27'b0, idex.id_rd}, 32'd1);
    mdu_done = 1'b1;
    #1;
    check("div_done_stall", {31'b0, id_stall}, 32'd1);
    tick();
    mdu_done = 1'b0;
    #1;
    check("div_run_stall", {31'b0, id_stall}, 32'd0);
    tick();
    check("div_next_rd", {27'b0, idex.id_rd}, 32'd5);
    check("div_next_valid", {31'b0, idex.id_valid}, 32'd1);
    check("div_start_count", start_cnt - s0, 32'd1);

    // flush together with mdu_done inside MDU_WAIT
    s0 = start_cnt;
    drive(1'b1, I_DIV, 32'h300);
    tick();
    drive(1'b1, I_ADDI, 32'h304);
    tick(); tick();
    ex_flush = 1'b1; mdu_done = 1'b1;
    #1;
    check("fl_stall", {31'b0, id_stall}, 32'd0);
    tick();
    check("fl_valid", {31'b0, idex.id_valid}, 32'd0);
    check("fl_we", {31'b0, idex.id_reg_write}, 32'd0);
    check("fl_start", {31'b0, idex.id_mdu_start}, 32'd0);
    ex_flush = 1'b0; mdu_done = 1'b0;
    #1;
    check("fl_run_stall", {31'b0, id_stall}, 32'd0);
    tick();
    check("fl_next_valid", {31'b0, idex.id_valid}, 32'd1);
    check("fl_start_count", start_cnt - s0, 32'd1);

    // immediate select and illegal opcode
    drive(1'b1, I_BEQ, 32'h400);
    #1;
    check("beq_imm_src", {30'b0, imm_src}, 32'd2);
    tick();
    check("beq_imm", idex.id_imm, 32'hFFFFFFFC);
    check("beq_branch", {31'b0, idex.id_branch}, 32'd1);
    check("beq_we", {31'b0, idex.id_reg_write}, 32'd0);
    drive(1'b1, I_LUI, 32'h404);
    tick();
    check("lui_imm", idex.id_imm, 32'h12345000);
    check("lui_we", {31'b0, idex.id_reg_write}, 32'd1);
    drive(1'b1, I_JAL, 32'h408);
    #1;
    check("jal_imm_src", {30'b0, imm_src}, 32'd3);
    drive(1'b1, I_SW, 32'h40C);
    #1;
    check("sw_imm_src", {30'b0, imm_src}, 32'd1);
    tick();
    check("sw_mem_write", {31'b0, idex.id_mem_write}, 32'd1);
    drive(1'b1, I_BAD, 32'h410);
    #1;
    check("bad_imm_src", {30'b0, imm_src}, 32'd0);
    tick();
    check("bad_illegal", {31'b0, idex.id_illegal}, 32'd1);
    check("bad_valid", {31'b0, idex.id_valid}, 32'd1);
    check("bad_we", {28'b0, idex.id_reg_write, idex.id_mem_write, idex.id_branch, idex.id_jump}, 32'd0);

    // reset mid-MDU_WAIT
    drive(1'b1, I_DIV, 32'h500);
    tick();
    check("rw_start", {31'b0, idex.id_mdu_start}, 32'd1);
    drive(1'b1, I_ADDI, 32'h504);
    tick();
    check("rw_stall", {31'b0, id_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_valid", {31'b0, idex.id_valid}, 32'd0);
    check("rw_stall0", {31'b0, id_stall}, 32'd0);
    check("rw_rd", {27'b0, idex.id_rd}, 32'd0);
    check("rw_imm", idex.id_imm, 32'd0);
    #3;
    rst_n = 1'b1;
    #1;
    check("rw_run_stall", {31'b0, id_stall}, 32'd0);
    tick();
    check("rw_next_valid", {31'b0, idex.id_valid}, 32'd1);
    check("rw_next_rd", {27'b0, idex.id_rd}, 32'd5);
    check("rw_next_start", {31'b0, idex.id_mdu_start}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single core clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs if_valid (1), if_instr (32) and if_pc (32), the IF/ID stage contents.
REQ-004 SHALL have output imm_src (2), combinational select to the immediate extender, and input imm_ext (32), the extender result.
REQ-005 SHALL have inputs ex_flush (1, branch/jump taken in EX), ex_is_load (1), ex_rd (5) and mdu_done (1, divider result ready).
REQ-006 SHALL have output id_stall (1), which holds IF/ID and the PC.
REQ-007 SHALL have registered ID/EX outputs: id_valid (1), id_pc (32), id_imm (32), id_rs1, id_rs2, id_rd (5 each), id_alu_ctrl (4), id_alu_src (1), id_result_src (2), id_reg_write, id_mem_write, id_branch, id_jump, id_is_load (1 each), id_illegal (1) and id_mdu_start (1).

Function
REQ-008 SHALL drive imm_src from if_instr[6:0] as follows: load, OP-IMM and JALR give 00; STORE gives 01; BRANCH gives 10; JAL gives 11; every other opcode gives 00.
REQ-009 SHALL take id_imm from imm_ext, except for LUI/AUIPC, where id_imm = {if_instr[31:12], 12'b0}.
REQ-010 SHALL register all decoded fields into the ID/EX outputs with 1-cycle latency when advancing.
REQ-011 SHALL run a 2-state FSM, RUN and MDU_WAIT.
REQ-012 SHALL raise the load-use hazard when ex_is_load=1, ex_rd!=0, and ex_rd equals if_instr[19:15] or if_instr[24:20], qualified by if_valid.
REQ-013 SHALL apply this priority each cycle: ex_flush first, then MDU_WAIT, then the load-use hazard, then normal advance.
REQ-014 SHALL on ex_flush load a bubble (id_valid=0, all write enables 0), deassert id_stall and force RUN, regardless of the current state.
REQ-015 SHALL in MDU_WAIT assert id_stall, hold all ID/EX outputs, and return to RUN in the cycle after mdu_done=1, advancing normally in that cycle.
REQ-016 SHALL on a load-use hazard assert id_stall combinationally and load a bubble for exactly one cycle.
REQ-017 SHALL on a normal advance set id_valid=if_valid.
REQ-018 SHALL on advancing a DIV/DIVU/REM/REMU (opcode 0110011, funct7 0000001, funct3[2]=1) with if_valid=1 pulse id_mdu_start for 1 cycle and enter MDU_WAIT.
REQ-019 SHALL treat MUL-class M instructions as single-cycle with no FSM transition.
REQ-020 SHALL on an unsupported opcode with if_valid=1 advance with id_illegal=1, id_valid=1 and all write enables 0.
REQ-021 SHALL ignore mdu_done in RUN.
REQ-022 SHALL, when ex_flush and mdu_done coincide, take the flush outcome.

Reset
REQ-023 SHALL on rst_n=0 asynchronously force state RUN, all ID/EX outputs 0 (id_valid=0, id_mdu_start=0) and id_stall=0.
REQ-024 SHALL on reset asserted mid-MDU_WAIT abandon the wait, with no pending start afterwards.
REQ-025 SHALL update on the first rising clk edge after rst_n deasserts.

Structure
REQ-026 SHALL take opcode constants, the imm_src encoding, the alu_ctrl encoding and the FSM state enum from shared package core_pkg.
REQ-027 SHALL place combinational opcode/funct decode in sub-module id_decoder; hazard logic, FSM and ID/EX registers live in id_ctrl.

Verification
REQ-028 SHALL cover: addi x5,x0,-1 (0xFFF00293), valid -> next cycle id_imm=0xFFFFFFFF, id_rd=5, id_alu_src=1, id_reg_write=1, imm_src=00.
REQ-029 SHALL cover: ex_is_load=1, ex_rd=5, instr add x6,x5,x7 -> id_stall=1 for 1 cycle with one bubble; the add issues next cycle.
REQ-030 SHALL cover: div x1,x2,x3 issues -> id_mdu_start pulses once, id_stall=1 until mdu_done asserts at cycle +7, RUN at cycle +8.
REQ-031 SHALL cover: ex_flush=1 in MDU_WAIT together with mdu_done=1 -> bubble, RUN, id_stall=0, no second id_mdu_start.
REQ-032 SHALL cover: beq with imm −4 -> imm_src=10; lui x1,0x12345 -> id_imm=0x12345000; opcode 0x7F -> id_illegal=1, no write enables.
REQ-033 SHALL cover: rst_n pulsed low mid-MDU_WAIT -> all outputs 0 immediately, RUN after release.
